level_controller: RTL and testbench
===================================

LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter ROUND_SECONDS, default 60, round length in seconds (1..255).
REQ-003 SHALL have parameter LEVEL_STEP, default 10, points per level advance (1..63).
REQ-004 SHALL have parameter BASE_SPEED, default 50000000, level-0 mole period in cycles.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: start request, sampled each clock.
REQ-008 SHALL have port score, input, 8 bits: live score from the player stage.
REQ-009 SHALL have port game, output, 1 bit: round active; drives the game input of the mole logic.
REQ-010 SHALL have port speed, output, 28 bits: mole display period for the mole logic.
REQ-011 SHALL have port level, output, 2 bits: current level, 0..3.
REQ-012 SHALL have port time_left, output, 8 bits: seconds remaining in the round.
REQ-013 SHALL have port game_over, output, 1 bit: high while in the OVER state.
REQ-014 SHALL have port final_score, output, 8 bits: score latched at round end.
REQ-015 SHALL have port high_score, output, 8 bits: best final_score since reset.

Function
REQ-016 SHALL implement states IDLE, PLAY and OVER, all registered.
REQ-017 SHALL drive game=1 only in PLAY and game_over=1 only in OVER.
REQ-018 IDLE with start=1 SHALL enter PLAY next cycle, loading time_left=ROUND_SECONDS, level=0 and prescaler=0.
REQ-019 OVER with start=1 SHALL enter PLAY next cycle with the same loads; final_score and high_score are held.
REQ-020 start SHALL be ignored in PLAY.
REQ-021 In PLAY, the prescaler SHALL count 0..CLK_HZ-1 and wrap, asserting a one-cycle tick on the wrap cycle.
REQ-022 On tick, time_left SHALL decrement by 1.
REQ-023 A tick with time_left==1 SHALL set time_left=0 and enter OVER, so PLAY lasts exactly ROUND_SECONDS*CLK_HZ cycles.
REQ-024 On the PLAY->OVER cycle, final_score SHALL capture score as sampled that cycle, because the player stage clears score once game falls.
REQ-025 In PLAY, when level<3 and score>=(level+1)*LEVEL_STEP, level SHALL increment by 1 next cycle, at most one step per cycle.
REQ-026 The level threshold compare SHALL be at least 9 bits wide, with no overflow.
REQ-027 level SHALL never decrease within a round, even when score drops; it saturates at 3.
REQ-028 speed SHALL equal BASE_SPEED >> level (28-bit) and be registered, updating the cycle after level changes.
REQ-029 When a level-up and the final tick occur in the same cycle, the transition to OVER SHALL win and level SHALL hold.

Reset
REQ-030 reset=1 SHALL, at the next edge, force:
- state=IDLE, game=0, game_over=0
- level=0, speed=BASE_SPEED
- time_left=0, prescaler=0
- final_score=0, high_score=0
REQ-031 reset SHALL take priority over start and tick in every state, including mid-round.

Configuration
REQ-032 Macro LEVEL_CONTROLLER_HIGH_SCORE_EN SHALL control the high-score register.
REQ-033 With LEVEL_CONTROLLER_HIGH_SCORE_EN defined, on the PLAY->OVER cycle high_score SHALL update to score if score>high_score (strict).
REQ-034 Without LEVEL_CONTROLLER_HIGH_SCORE_EN, high_score SHALL be constant 0 and no register SHALL be inferred for it.

Verification (CLK_HZ=4, ROUND_SECONDS=3, LEVEL_STEP=2, BASE_SPEED=1000)
REQ-035 Reset, then start=1 for one cycle -> next cycle game=1, time_left=3, level=0, speed=1000.
REQ-036 Hold score=0 through the round -> time_left reads 2, 1, 0 at 4-cycle intervals; game falls and game_over rises after exactly 12 PLAY cycles; final_score=0.
REQ-037 score steps 2->4->7, then drops to 1 -> level goes 1, 2, 3 and stays 3; speed goes 500, 250, 125.
REQ-038 score=9 on the final tick cycle -> final_score=9 and, with the macro, high_score=9; next round ending at 5 -> high_score stays 9.
REQ-039 reset asserted mid-PLAY with time_left=2 and level=2 -> next cycle IDLE, game=0, level=0, speed=1000, time_left=0.
REQ-040 start held high through an entire round -> no restart during PLAY; a new PLAY begins the cycle after OVER is entered.

Source files
------------

// File: rtl/level_controller.sv
// level_controller: round timer, level scaler and score latch for the mole game.
// A round runs ROUND_SECONDS one-second ticks; the level climbs with the live score
// and halves the mole period each step. Defining LEVEL_CONTROLLER_HIGH_SCORE_EN
// adds a best-score register; without it high_score is tied to zero.
module level_controller #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned ROUND_SECONDS = 60,
    parameter int unsigned LEVEL_STEP    = 10,
    parameter int unsigned BASE_SPEED    = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  score,
    output logic        game,
    output logic [27:0] speed,
    output logic [1:0]  level,
    output logic [7:0]  time_left,
    output logic        game_over,
    output logic [7:0]  final_score,
    output logic [7:0]  high_score
);

    localparam int unsigned     PreW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PreW-1:0] PreMax    = PreW'(CLK_HZ - 1);
    localparam logic [7:0]      RoundLoad = 8'(ROUND_SECONDS);
    localparam logic [8:0]      StepW     = 9'(LEVEL_STEP);
    localparam logic [27:0]     BaseSpeed = 28'(BASE_SPEED);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StOver
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [PreW-1:0] r_prescaler;
    logic [7:0]      r_time_left;
    logic [1:0]      r_level;
    logic [27:0]     r_speed;
    logic [7:0]      r_final_score;

    logic            w_tick;
    logic            w_round_start;
    logic            w_round_end;
    logic            w_level_up;
    logic [8:0]      w_threshold;

    // One-cycle pulse on the prescaler wrap, only while a round is running.
    assign w_tick = (r_state == StPlay) && (r_prescaler == PreMax);

    // Score needed for the next level; 9 bits so (level+1)*LEVEL_STEP cannot wrap.
    assign w_threshold = ({7'd0, r_level} + 9'd1) * StepW;

    // The final tick takes precedence over a coincident level-up.
    assign w_level_up = (r_state == StPlay) && !w_round_end && (r_level != 2'd3) &&
                        ({1'b0, score} >= w_threshold);

    // Next-state decode; start is only honoured outside PLAY.
    always_comb begin
        w_state_next  = r_state;
        w_round_start = 1'b0;
        w_round_end   = 1'b0;
        case (r_state)
            StIdle, StOver: begin
                if (start) begin
                    w_state_next  = StPlay;
                    w_round_start = 1'b1;
                end
            end
            StPlay: begin
                if (w_tick && (r_time_left == 8'd1)) begin
                    w_state_next = StOver;
                    w_round_end  = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Prescaler and seconds countdown; both reload when a round starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescaler <= '0;
            r_time_left <= '0;
        end else if (w_round_start) begin
            r_prescaler <= '0;
            r_time_left <= RoundLoad;
        end else if (r_state == StPlay) begin
            if (w_tick) begin
                r_prescaler <= '0;
                r_time_left <= r_time_left - 8'd1;
            end else begin
                r_prescaler <= r_prescaler + PreW'(1);
            end
        end
    end

    // Level only climbs within a round, one step per cycle, saturating at 3.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= 2'd0;
        end else if (w_round_start) begin
            r_level <= 2'd0;
        end else if (w_level_up) begin
            r_level <= r_level + 2'd1;
        end
    end

    // Mole period follows the level one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_speed <= BaseSpeed;
        end else begin
            r_speed <= BaseSpeed >> r_level;
        end
    end

    // Capture score on the PLAY->OVER edge, before the player stage clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_final_score <= 8'd0;
        end else if (w_round_end) begin
            r_final_score <= score;
        end
    end

`ifdef LEVEL_CONTROLLER_HIGH_SCORE_EN
    logic [7:0] r_high_score;

    // Best final score since reset; ties leave it unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_high_score <= 8'd0;
        end else if (w_round_end && (score > r_high_score)) begin
            r_high_score <= score;
        end
    end

    assign high_score = r_high_score;
`else
    assign high_score = 8'd0;
`endif

    assign game        = (r_state == StPlay);
    assign game_over   = (r_state == StOver);
    assign level       = r_level;
    assign speed       = r_speed;
    assign time_left   = r_time_left;
    assign final_score = r_final_score;

endmodule

// File: tb/tb_level_controller.sv
// Bench for level_controller: constant-vector table, directed round scenarios and
// random stimulus compared each cycle with an arithmetic round model.
module tb_level_controller;

    localparam int unsigned CLK_HZ        = 4;
    localparam int unsigned ROUND_SECONDS = 3;
    localparam int unsigned LEVEL_STEP    = 2;
    localparam int unsigned BASE_SPEED    = 1000;
    localparam int          RoundCycles   = ROUND_SECONDS * CLK_HZ;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  score = 8'd0;
    logic        game;
    logic [27:0] speed;
    logic [1:0]  level;
    logic [7:0]  time_left;
    logic        game_over;
    logic [7:0]  final_score;
    logic [7:0]  high_score;

    level_controller #(
        .CLK_HZ        (CLK_HZ),
        .ROUND_SECONDS (ROUND_SECONDS),
        .LEVEL_STEP    (LEVEL_STEP),
        .BASE_SPEED    (BASE_SPEED)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .score       (score),
        .game        (game),
        .speed       (speed),
        .level       (level),
        .time_left   (time_left),
        .game_over   (game_over),
        .final_score (final_score),
        .high_score  (high_score)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Round model: mode 0 idle, 1 play, 2 over; m_n counts PLAY cycles elapsed.
    int m_mode  = 0;
    int m_n     = 0;
    int m_level = 0;
    int m_speed = BASE_SPEED;
    int m_tl    = 0;
    int m_fs    = 0;
    int m_hs    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance the model over one clock edge using the inputs presented to it.
    task automatic model_step();
        int spd;
        int sc;
        sc = int'(score);
        if (reset) begin
            m_mode  = 0;
            m_n     = 0;
            m_level = 0;
            m_speed = BASE_SPEED;
            m_tl    = 0;
            m_fs    = 0;
            m_hs    = 0;
            return;
        end
        spd = BASE_SPEED >> m_level;
        if (m_mode == 1) begin
            if (m_n == RoundCycles - 1) begin
                m_mode = 2;
                m_tl   = 0;
                m_fs   = sc;
`ifdef LEVEL_CONTROLLER_HIGH_SCORE_EN
                if (sc > m_hs) m_hs = sc;
`endif
            end else begin
                if (m_level < 3 && sc >= (m_level + 1) * LEVEL_STEP) m_level++;
                m_n++;
                m_tl = ROUND_SECONDS - m_n / CLK_HZ;
            end
        end else if (start) begin
            m_mode  = 1;
            m_n     = 0;
            m_level = 0;
            m_tl    = ROUND_SECONDS;
        end
        m_speed = spd;
    endtask

    // One clock: update the model at the edge, sample the DUT 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("m_game", game, longint'(m_mode == 1));
        chk("m_game_over", game_over, longint'(m_mode == 2));
        chk("m_level", level, m_level);
        chk("m_speed", speed, m_speed);
        chk("m_time_left", time_left, m_tl);
        chk("m_final_score", final_score, m_fs);
        chk("m_high_score", high_score, m_hs);
    endtask

    typedef struct {
        logic       rst;
        logic       st;
        logic [7:0] sc;
        logic       eg;
        int         el;
        int         es;
        int         et;
    } vec_t;

    vec_t tbl[7];
    int   play_cnt;
    int   tl_seen[64];
    int   exp_hs;

    initial begin
        // reset, start, then score 2 -> 4 -> 7 -> 1: level 1,2,3 held; speed lags one cycle
        tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 0, 1000, 0};
        tbl[1] = '{1'b0, 1'b1, 8'd0, 1'b1, 0, 1000, 3};
        tbl[2] = '{1'b0, 1'b0, 8'd2, 1'b1, 1, 1000, 3};
        tbl[3] = '{1'b0, 1'b0, 8'd4, 1'b1, 2, 500,  3};
        tbl[4] = '{1'b0, 1'b0, 8'd7, 1'b1, 3, 250,  3};
        tbl[5] = '{1'b0, 1'b0, 8'd1, 1'b1, 3, 125,  2};
        tbl[6] = '{1'b0, 1'b0, 8'd1, 1'b1, 3, 125,  2};

        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst;
            start = tbl[i].st;
            score = tbl[i].sc;
            cycle();
            chk($sformatf("vec%0d_game", i), game, tbl[i].eg);
            chk($sformatf("vec%0d_level", i), level, tbl[i].el);
            chk($sformatf("vec%0d_speed", i), speed, tbl[i].es);
            chk($sformatf("vec%0d_time_left", i), time_left, tbl[i].et);
        end

        // Full round with score 0: 12 PLAY cycles, time_left 3,2,1 at 4-cycle steps.
        reset = 1'b1;
        start = 1'b0;
        score = 8'd0;
        cycle();
        reset = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        play_cnt = 0;
        while (game && play_cnt < 50) begin
            tl_seen[play_cnt] = int'(time_left);
            play_cnt++;
            cycle();
        end
        chk("round_len", play_cnt, RoundCycles);
        chk("round_tl0", tl_seen[0], 3);
        chk("round_tl3", tl_seen[3], 3);
        chk("round_tl4", tl_seen[4], 2);
        chk("round_tl8", tl_seen[8], 1);
        chk("round_tl11", tl_seen[11], 1);
        chk("round_over", game_over, 1);
        chk("round_tl_end", time_left, 0);
        chk("round_final", final_score, 0);

        // Score 9 only on the final tick: captured, and the level-up loses to OVER.
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < RoundCycles - 1; i++) cycle();
        score = 8'd9;
        cycle();
        score = 8'd0;
`ifdef LEVEL_CONTROLLER_HIGH_SCORE_EN
        exp_hs = 9;
`else
        exp_hs = 0;
`endif
        chk("end9_over", game_over, 1);
        chk("end9_final", final_score, 9);
        chk("end9_high", high_score, exp_hs);
        chk("end9_level_hold", level, 0);

        // Next round ends at 5: high score keeps 9.
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_final_held", final_score, 9);
        for (int i = 0; i < RoundCycles - 1; i++) cycle();
        score = 8'd5;
        cycle();
        score = 8'd0;
        chk("end5_final", final_score, 5);
        chk("end5_high", high_score, exp_hs);

        // Reset mid-round at time_left=2, level=2.
        start = 1'b1;
        cycle();
        start = 1'b0;
        score = 8'd4;
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_level", level, 2);
        chk("mid_tl", time_left, 2);
        reset = 1'b1;
        cycle();
        chk("mid_rst_game", game, 0);
        chk("mid_rst_over", game_over, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_speed", speed, BASE_SPEED);
        chk("mid_rst_tl", time_left, 0);
        chk("mid_rst_high", high_score, 0);
        reset = 1'b0;
        score = 8'd0;

        // start held through a round: no restart in PLAY, one OVER cycle, then PLAY.
        start = 1'b1;
        cycle();
        play_cnt = 0;
        while (game && play_cnt < 50) begin
            play_cnt++;
            cycle();
        end
        chk("held_len", play_cnt, RoundCycles);
        chk("held_over", game_over, 1);
        cycle();
        chk("held_restart_game", game, 1);
        chk("held_restart_tl", time_left, ROUND_SECONDS);
        start = 1'b0;

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) score = 8'($urandom_range(0, 255));
            else score = 8'($urandom_range(0, 10));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
